// File: rtl/alu_wf_arbiter.sv
// Per-FU-class wavefront arbiter feeding the ALU issue stage: round-robin pick among
// ready wavefronts, with a just-issued wavefront masked for LOCK_DEPTH cycles.
module alu_wf_arbiter #(
    parameter int NUM_WF      = 40,
    parameter int WF_ID_WIDTH = 6,
    parameter int LOCK_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_WF-1:0]      wf_ready,
    input  logic                   class_issued,
    output logic                   wf_valid,
    output logic [WF_ID_WIDTH-1:0] wf_chosen,
    output logic                   err_spurious_issue
);

    // Handshake: wf_valid/wf_chosen are offered every cycle and never depend on
    // class_issued; class_issued with wf_valid high consumes wf_chosen that cycle,
    // class_issued with wf_valid low is a protocol error and changes nothing else.

    localparam logic [WF_ID_WIDTH-1:0] LAST_ID = WF_ID_WIDTH'(NUM_WF - 1);

    logic [WF_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic                   lv_q  [LOCK_DEPTH];
    logic [WF_ID_WIDTH-1:0] lid_q [LOCK_DEPTH];
    logic                   err_q, err_d;

    logic [NUM_WF-1:0]      locked_mask;
    logic [NUM_WF-1:0]      eligible;
    logic                   found_hi, found_lo;
    logic [WF_ID_WIDTH-1:0] idx_hi, idx_lo, pick;
    logic                   accept;

    always_comb begin
        locked_mask = '0;
        for (int i = 0; i < NUM_WF; i++) begin
            for (int e = 0; e < LOCK_DEPTH; e++) begin
                if (lv_q[e] && (lid_q[e] == WF_ID_WIDTH'(i))) begin
                    locked_mask[i] = 1'b1;
                end
            end
        end
    end

    assign eligible = wf_ready & ~locked_mask;

    // Rotating priority split into two fixed-priority searches: lowest eligible
    // index at or above ptr, else lowest eligible index overall (the wrapped part).
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int i = NUM_WF - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                found_lo = 1'b1;
                idx_lo   = WF_ID_WIDTH'(i);
                if (i >= int'(ptr_q)) begin
                    found_hi = 1'b1;
                    idx_hi   = WF_ID_WIDTH'(i);
                end
            end
        end
        pick = found_hi ? idx_hi : idx_lo;
    end

    assign wf_valid           = found_lo && !rst;
    assign wf_chosen          = wf_valid ? pick : '0;
    assign err_spurious_issue = err_q;
    assign accept             = class_issued && wf_valid;

    always_comb begin
        ptr_d = ptr_q;
        err_d = err_q;
        if (accept) begin
            ptr_d = (wf_chosen == LAST_ID) ? '0 : wf_chosen + 1'b1;
        end
        if (class_issued && !wf_valid) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            err_q <= 1'b0;
            for (int e = 0; e < LOCK_DEPTH; e++) begin
                lv_q[e]  <= 1'b0;
                lid_q[e] <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            err_q    <= err_d;
            // Locks age every cycle; an invalid entry is shifted in when nothing issued.
            lv_q[0]  <= accept;
            lid_q[0] <= wf_chosen;
            for (int e = 1; e < LOCK_DEPTH; e++) begin
                lv_q[e]  <= lv_q[e-1];
                lid_q[e] <= lid_q[e-1];
            end
        end
    end

endmodule
